// File: rtl/eq_gain_sequencer.sv
// EQ gain RAM write sequencer: shadow->target on commit, writes RAM only in inter-frame gaps, optional per-frame ramp.
// Commit to first RAM write is 3 cycles when idle; any non-gap cycle pauses the write pass in place.
module eq_gain_sequencer #(
  parameter int NUM_OF_FILTERS = 4,
  parameter int GAIN_W         = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cpu_wr_i,
  input  logic [3:0]        cpu_sel_i,
  input  logic [GAIN_W-1:0] cpu_gain_i,
  input  logic              commit_i,
  input  logic [GAIN_W-1:0] ramp_step_i,
  input  logic              frame_stb_i,
  input  logic              eq_busy_i,
  output logic              ram_we_o,
  output logic [3:0]        ram_addr_o,
  output logic [GAIN_W-1:0] ram_d_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              commit_pending_o
);

  typedef enum logic [1:0] {IDLE, WAIT_GAP, UPDATE, WAIT_FRAME} state_t;
  localparam logic [3:0] LAST_IDX = 4'(NUM_OF_FILTERS - 1);

  state_t            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic              commit_pending_q, commit_pending_d;
  logic              done_q, done_d;
  logic [GAIN_W-1:0] shadow_q  [NUM_OF_FILTERS];
  logic [GAIN_W-1:0] target_q  [NUM_OF_FILTERS];
  logic [GAIN_W-1:0] current_q [NUM_OF_FILTERS];

  logic              gap, wr_en, xfer, all_eq;
  logic [GAIN_W-1:0] tgt_sel, cur_sel, next_val;
  logic [GAIN_W:0]   diff, diff_mag, step_ext;

  assign gap   = !eq_busy_i && !frame_stb_i;
  assign wr_en = (state_q == UPDATE) && gap;

  always_comb begin
    tgt_sel = '0;
    cur_sel = '0;
    for (int i = 0; i < NUM_OF_FILTERS; i++) begin
      if (idx_q == 4'(i)) begin
        tgt_sel = target_q[i];
        cur_sel = current_q[i];
      end
    end
  end

  // One extra bit keeps the difference exact, so the step never overshoots or wraps.
  always_comb begin
    diff     = {tgt_sel[GAIN_W-1], tgt_sel} - {cur_sel[GAIN_W-1], cur_sel};
    diff_mag = diff[GAIN_W] ? (~diff + {{GAIN_W{1'b0}}, 1'b1}) : diff;
    step_ext = {1'b0, ramp_step_i};
    next_val = tgt_sel;
    if (ramp_step_i != '0 && diff_mag > step_ext) begin
      if (!diff[GAIN_W]) next_val = cur_sel + ramp_step_i;
      else               next_val = cur_sel - ramp_step_i;
    end
  end

  always_comb begin
    all_eq = 1'b1;
    for (int i = 0; i < NUM_OF_FILTERS; i++) begin
      if (((wr_en && idx_q == 4'(i)) ? next_val : current_q[i]) != target_q[i]) all_eq = 1'b0;
    end
  end

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    commit_pending_d = commit_pending_q | commit_i;
    done_d           = 1'b0;
    xfer             = 1'b0;
    case (state_q)
      IDLE: begin
        if (commit_pending_q) state_d = WAIT_GAP;
      end
      WAIT_GAP: begin
        if (gap) begin
          if (commit_pending_q) begin
            xfer             = 1'b1;
            commit_pending_d = commit_i;
          end
          idx_d   = '0;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        if (gap) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (all_eq) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = WAIT_FRAME;
            end
          end
        end
      end
      WAIT_FRAME: begin
        if (frame_stb_i) state_d = WAIT_GAP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q          <= IDLE;
      idx_q            <= '0;
      commit_pending_q <= 1'b0;
      done_q           <= 1'b0;
      for (int i = 0; i < NUM_OF_FILTERS; i++) begin
        shadow_q[i]  <= '0;
        target_q[i]  <= '0;
        current_q[i] <= '0;
      end
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      commit_pending_q <= commit_pending_d;
      done_q           <= done_d;
      for (int i = 0; i < NUM_OF_FILTERS; i++) begin
        if (cpu_wr_i && cpu_sel_i == 4'(i)) shadow_q[i] <= cpu_gain_i;
        if (xfer) target_q[i] <= shadow_q[i];
        if (wr_en && idx_q == 4'(i)) current_q[i] <= next_val;
      end
    end
  end

  assign ram_we_o         = wr_en;
  assign ram_addr_o       = wr_en ? idx_q : 4'd0;
  assign ram_d_o          = wr_en ? next_val : '0;
  assign busy_o           = (state_q != IDLE);
  assign done_o           = done_q;
  assign commit_pending_o = commit_pending_q;

endmodule

// File: tb/tb_eq_gain_sequencer.sv
// Bench for eq_gain_sequencer: directed scenarios plus randomized rounds, every RAM write checked
// against a per-pass ramp model of the gain bank.
module tb_eq_gain_sequencer;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        cpu_wr_i = 1'b0;
  logic [3:0]  cpu_sel_i = '0;
  logic [15:0] cpu_gain_i = '0;
  logic        commit_i = 1'b0;
  logic [15:0] ramp_step_i = '0;
  logic        frame_stb_i = 1'b0;
  logic        eq_busy_i = 1'b0;
  logic        ram_we_o;
  logic [3:0]  ram_addr_o;
  logic [15:0] ram_d_o;
  logic        busy_o, done_o, commit_pending_o;

  eq_gain_sequencer #(.NUM_OF_FILTERS(N), .GAIN_W(16)) dut (
    .clk_i(clk), .reset_i(reset_i), .cpu_wr_i(cpu_wr_i), .cpu_sel_i(cpu_sel_i),
    .cpu_gain_i(cpu_gain_i), .commit_i(commit_i), .ramp_step_i(ramp_step_i),
    .frame_stb_i(frame_stb_i), .eq_busy_i(eq_busy_i), .ram_we_o(ram_we_o),
    .ram_addr_o(ram_addr_o), .ram_d_o(ram_d_o), .busy_o(busy_o), .done_o(done_o),
    .commit_pending_o(commit_pending_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // Reference state: shadow/target/current gain banks and the write log per address.
  logic [15:0] shadow_m [N];
  logic [15:0] target_m [N];
  logic [15:0] current_m [N];
  logic [15:0] wlog [N][$];
  bit pend_m;
  bit done_exp;
  int wcnt;
  int n_writes = 0;
  int frame_period = 0;
  int fcnt = 0;
  bit rand_busy = 0;
  bit tests_done = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] ramp_ref(input logic [15:0] cur, input logic [15:0] tgt,
                                           input logic [15:0] step);
    int c, t, s, d, mag;
    c = int'($signed(cur));
    t = int'($signed(tgt));
    s = int'(step);
    d = t - c;
    mag = (d < 0) ? -d : d;
    if (s == 0 || mag <= s) return tgt;
    return (d > 0) ? 16'(c + s) : 16'(c - s);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      shadow_m[i] = '0;
      target_m[i] = '0;
      current_m[i] = '0;
    end
    pend_m = 0;
    done_exp = 0;
    wcnt = 0;
  endtask

  task automatic clear_log();
    for (int i = 0; i < N; i++) wlog[i].delete();
  endtask

  task automatic monitor_loop();
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (reset_i) begin
        model_reset();
        continue;
      end
      chk_val("done_pulse", done_o, done_exp);
      done_exp = 0;
      if (eq_busy_i || frame_stb_i) chk_val("no_write_outside_gap", ram_we_o, 0);
      if (ram_we_o) begin
        if (wcnt == 0 && pend_m) begin
          target_m = shadow_m;
          pend_m = 0;
        end
        chk_val("wr_addr", ram_addr_o, wcnt);
        e = ramp_ref(current_m[wcnt], target_m[wcnt], ramp_step_i);
        chk_val("wr_data", ram_d_o, e);
        current_m[wcnt] = e;
        wlog[wcnt].push_back(ram_d_o);
        n_writes++;
        wcnt++;
        if (wcnt == N) begin
          wcnt = 0;
          done_exp = 1;
          for (int i = 0; i < N; i++) if (current_m[i] != target_m[i]) done_exp = 0;
        end
      end else begin
        chk_val("bus_zero_when_no_write", {ram_addr_o, ram_d_o}, 0);
      end
      if (cpu_wr_i && cpu_sel_i < N) shadow_m[cpu_sel_i] = cpu_gain_i;
      if (commit_i) pend_m = 1;
    end
  endtask

  task automatic frame_loop();
    forever begin
      @(posedge clk); #1;
      fcnt++;
      if (frame_period != 0 && fcnt >= frame_period) begin
        frame_stb_i = 1'b1;
        fcnt = 0;
      end else begin
        frame_stb_i = 1'b0;
      end
    end
  endtask

  task automatic busy_loop();
    forever begin
      @(posedge clk); #1;
      if (rand_busy) eq_busy_i = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic cpu_write(input logic [3:0] sel, input logic [15:0] g, input bit with_commit);
    cpu_wr_i = 1'b1;
    cpu_sel_i = sel;
    cpu_gain_i = g;
    commit_i = with_commit;
    cyc();
    cpu_wr_i = 1'b0;
    commit_i = 1'b0;
  endtask

  task automatic pulse_reset();
    reset_i = 1'b1;
    cyc();
    reset_i = 1'b0;
    cyc();
  endtask

  task automatic wait_write(input logic [3:0] addr, input int limit, output int cycles);
    cycles = -1;
    for (int k = 1; k <= limit && cycles < 0; k++) begin
      @(negedge clk);
      if (ram_we_o && ram_addr_o == addr) cycles = k;
    end
  endtask

  task automatic wait_done(input string tag, input int limit);
    bit seen;
    seen = 0;
    for (int k = 0; k < limit && !seen; k++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1;
        chk_val({tag, "_busy_low_with_done"}, busy_o, 0);
      end
    end
    chk_val({tag, "_done_seen"}, seen, 1);
    cyc();
  endtask

  task automatic run_tests();
    int c, nw0, v;
    logic [15:0] vals [N];
    logic [15:0] new_sh [N];

    // Reset held three cycles while the CPU side toggles.
    for (int k = 0; k < 3; k++) begin
      cpu_wr_i = (k % 2 == 0);
      cpu_sel_i = 4'(k);
      cpu_gain_i = 16'h5A5A;
      commit_i = (k % 2 == 1);
      cyc();
      @(negedge clk);
      chk_val("rst_ram_we", ram_we_o, 0);
      chk_val("rst_busy", busy_o, 0);
      chk_val("rst_done", done_o, 0);
      chk_val("rst_commit_pending", commit_pending_o, 0);
    end
    cpu_wr_i = 1'b0;
    commit_i = 1'b0;
    reset_i = 1'b0;
    cyc();

    // Direct load: last write and commit share a cycle.
    vals = '{16'h1000, 16'h2000, 16'hE000, 16'h7FFF};
    clear_log();
    nw0 = n_writes;
    for (int i = 0; i < N; i++) cpu_write(4'(i), vals[i], i == N - 1);
    wait_write(4'd0, 20, c);
    chk_val("t2_first_write_latency", c, 3);
    wait_done("t2", 20);
    chk_val("t2_write_count", n_writes - nw0, 4);
    for (int i = 0; i < N; i++) begin
      chk_val("t2_log_size", wlog[i].size(), 1);
      if (wlog[i].size() > 0) chk_val("t2_value", wlog[i][0], vals[i]);
    end

    // Upward ramp across frames.
    pulse_reset();
    clear_log();
    nw0 = n_writes;
    ramp_step_i = 16'h0100;
    fcnt = 0;
    frame_period = 50;
    cpu_write(4'd0, 16'h0300, 1);
    wait_done("t3", 400);
    chk_val("t3_pass_count", wlog[0].size(), 3);
    chk_val("t3_write_count", n_writes - nw0, 12);
    if (wlog[0].size() == 3) begin
      chk_val("t3_step1", wlog[0][0], 16'h0100);
      chk_val("t3_step2", wlog[0][1], 16'h0200);
      chk_val("t3_step3", wlog[0][2], 16'h0300);
    end

    // Downward ramp crossing zero.
    frame_period = 0;
    pulse_reset();
    ramp_step_i = 16'h0000;
    cpu_write(4'd1, 16'h0050, 1);
    wait_done("t4_preload", 40);
    clear_log();
    ramp_step_i = 16'h0040;
    fcnt = 0;
    frame_period = 50;
    cpu_write(4'd1, 16'hFF80, 1);
    wait_done("t4", 600);
    chk_val("t4_pass_count", wlog[1].size(), 4);
    if (wlog[1].size() == 4) begin
      chk_val("t4_step1", wlog[1][0], 16'h0010);
      chk_val("t4_step2", wlog[1][1], 16'hFFD0);
      chk_val("t4_step3", wlog[1][2], 16'hFF90);
      chk_val("t4_step4", wlog[1][3], 16'hFF80);
    end

    // Pause mid-pass on eq_busy.
    frame_period = 0;
    ramp_step_i = 16'h0000;
    clear_log();
    for (int i = 0; i < N; i++) cpu_write(4'(i), 16'($urandom), 0);
    nw0 = n_writes;
    commit_i = 1'b1;
    cyc();
    commit_i = 1'b0;
    wait_write(4'd1, 20, c);
    chk_val("t5_addr1_seen", c > 0, 1);
    cyc();
    eq_busy_i = 1'b1;
    @(negedge clk);
    chk_val("t5_paused", ram_we_o, 0);
    repeat (10) cyc();
    eq_busy_i = 1'b0;
    wait_write(4'd2, 5, c);
    chk_val("t5_resume_at_addr2", c > 0, 1);
    wait_done("t5", 20);
    chk_val("t5_write_count", n_writes - nw0, 4);

    // Commit latched while waiting for the next frame.
    pulse_reset();
    clear_log();
    ramp_step_i = 16'h0100;
    fcnt = 0;
    frame_period = 60;
    cpu_write(4'd0, 16'h0800, 0);
    cpu_write(4'd2, 16'hF900, 1);
    wait_write(4'd3, 20, c);
    chk_val("t6_first_pass_end", c > 0, 1);
    cyc();
    for (int i = 0; i < N; i++) begin
      v = int'($urandom_range(0, 2048)) - 1024;
      new_sh[i] = 16'(v);
      cpu_write(4'(i), new_sh[i], i == N - 1);
    end
    @(negedge clk);
    chk_val("t6_commit_pending", commit_pending_o, 1);
    chk_val("t6_still_busy", busy_o, 1);
    wait_done("t6", 3000);
    for (int i = 0; i < N; i++)
      if (wlog[i].size() > 0) chk_val("t6_final_gain", wlog[i][wlog[i].size() - 1], new_sh[i]);

    // Reset in the middle of a write pass, then recover with a fresh commit.
    frame_period = 0;
    ramp_step_i = 16'h0000;
    cpu_write(4'd1, 16'h1234, 1);
    wait_write(4'd1, 20, c);
    chk_val("t6b_addr1_seen", c > 0, 1);
    cyc();
    reset_i = 1'b1;
    cyc();
    reset_i = 1'b0;
    @(negedge clk);
    chk_val("t6b_we_after_reset", ram_we_o, 0);
    chk_val("t6b_busy_after_reset", busy_o, 0);
    cyc();
    clear_log();
    nw0 = n_writes;
    commit_i = 1'b1;
    cyc();
    commit_i = 1'b0;
    wait_done("t6b_recommit", 20);
    chk_val("t6b_write_count", n_writes - nw0, 4);

    // Randomized rounds: random gains, selects (some out of range), steps and busy windows.
    rand_busy = 1;
    frame_period = 40;
    for (int r = 0; r < 6; r++) begin
      ramp_step_i = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom_range(16'h0040, 16'h0180));
      for (int k = 0; k < 6; k++) begin
        v = int'($urandom_range(0, 3072)) - 1536;
        cpu_write(4'($urandom_range(0, 7)), 16'(v), k == 5);
      end
      wait_done("rnd", 4000);
    end
    rand_busy = 0;
    eq_busy_i = 1'b0;
    frame_period = 0;
    tests_done = 1;
  endtask

  initial begin
    model_reset();
    fork
      monitor_loop();
      frame_loop();
      busy_loop();
      begin
        #900000;
        chk_val("watchdog_tests_done", tests_done, 1);
      end
      run_tests();
    join_any
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/eq_gain_sequencer.md
Name: eq_gain_sequencer

Overview:
- Controller that owns the write port of the equalizer gain RAM.
- CPU writes per-filter target gains into a shadow bank; a commit strobe hands them to the sequencer.
- Sequencer writes gains into the RAM only in the idle gap between sample frames, so no frame mixes old and new gains.
- Optional per-frame ramp limits the gain change per frame to suppress zipper noise.

Parameters:
num_of_filters, 4, number of EQ filter gains managed (1..16)
gain_w, 16, gain word width (signed two's complement)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_wr  in  1  strobe: write cpu_gain into shadow[cpu_sel]
cpu_sel  in  4  shadow index; values >= num_of_filters ignored
cpu_gain  in  gain_w  target gain value
commit  in  1  strobe: request shadow->target transfer and update
ramp_step  in  gain_w  unsigned max change per frame; 0 = jump directly
frame_stb  in  1  one-cycle strobe at start of each EQ frame (right data enable)
eq_busy  in  1  EQ datapath is reading gains (run active)
ram_we  out  1  gain RAM write enable
ram_addr  out  4  gain RAM write address
ram_d  out  gain_w  gain RAM write data
busy  out  1  sequencer not IDLE
done  out  1  one-cycle pulse: RAM contents equal target bank
commit_pending  out  1  commit latched, not yet transferred

Behaviour:
- Storage: shadow[N], target[N], current[N] (mirror of RAM). All registers reset to 0.
- Reset: every output is 0 and the state is IDLE.
- Reset mid-pass: writing stops in the next cycle. The RAM is not cleared, and current[] is set to 0. Software must commit again.
- cpu_wr: updates shadow in the next cycle. It is legal in any state and never touches target directly.
- commit: sets commit_pending. A commit in the same cycle as cpu_wr includes that write.
- Gap condition: gap = !eq_busy && !frame_stb.
- States: IDLE, WAIT_GAP, UPDATE, WAIT_FRAME.
- IDLE: if commit_pending, go to WAIT_GAP.
- WAIT_GAP: on gap, do three things in the same edge:
  - If commit_pending, copy shadow->target and clear commit_pending.
  - Set idx=0.
  - Go to UPDATE.
- UPDATE, one index per cycle:
  - If gap: ram_we=1, ram_addr=idx, ram_d=next(idx), current[idx]<=next(idx), idx++.
  - If not gap: ram_we=0 and idx holds (pause). Resume at the same idx when gap returns; no index is skipped or repeated.
  - After idx = num_of_filters-1 is written: if every current equals its target (using the updated values), pulse done and go to IDLE; otherwise go to WAIT_FRAME.
- WAIT_FRAME: on frame_stb, go to WAIT_GAP. This gives exactly one ramp step per frame.
- Commit arriving during UPDATE or WAIT_FRAME: latched. The new targets are adopted at the start of the next pass; the current pass finishes on the old targets.
- Ramp arithmetic: diff = target - current in 17-bit signed.
  - If ramp_step==0 or |diff| <= ramp_step: next = target.
  - Else: next = current + ramp_step when diff>0, current - ramp_step when diff<0.
  - Never overshoots the target and never wraps.
- Latency, with eq_busy=0 and no frame_stb:
  - commit at edge T -> commit_pending=1 after T.
  - IDLE->WAIT_GAP at T+1; transfer and enter UPDATE at T+2.
  - ram_we high for cycles T+3 .. T+2+N.
  - done is high in the cycle after the last write, together with busy=0.
- A pass where every target already equals current still performs N writes, then pulses done.
- busy = (state != IDLE). ram_addr and ram_d are 0 whenever ram_we=0.

Test Plan:
1. Reset asserted 3 cycles, with cpu_wr/commit toggling -> ram_we, busy, done, commit_pending all 0; no RAM write.
2. ramp_step=0; shadow = {0x1000, 0x2000, 0xE000, 0x7FFF}; commit with eq_busy=0 -> 4 consecutive writes to addr 0..3 with exactly those values, starting 3 cycles after commit; done pulses once; busy falls with done.
3. current=0, target[0]=0x0300, step=0x0100, a frame_stb every 50 cycles -> three passes writing addr0 = 0x0100, 0x0200, 0x0300; done only after the third pass.
4. current[1]=0x0050, target=0xFF80, step=0x0040 -> successive addr1 writes 0x0010, 0xFFD0, 0xFF90, 0xFF80; no overshoot.
5. eq_busy raised right after addr1 is written, held 10 cycles -> ram_we=0 during busy; next write is addr2; total writes in the pass = 4.
6. Commit a new shadow during WAIT_FRAME of a ramp -> commit_pending=1, the next pass ramps toward the new targets. Separately, reset mid-UPDATE -> ram_we=0 next cycle, state IDLE.
